// File: rtl/rv32i_pkg.sv
// Shared RV32I constants for the MEM-stage load/store unit.
// Holds funct3 width/sign codes and LSU FSM state encodings.
package rv32i_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t LSU_IDLE = 2'd0;
    localparam lsu_state_t LSU_REQ  = 2'd1;
    localparam lsu_state_t LSU_RESP = 2'd2;

endpackage

// File: rtl/lsu_load_extend.sv
// Load data lane select and sign/zero extension.
// Purely combinational; driven by the latched offset and funct3.
module lsu_load_extend
    import rv32i_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[{a, 3'b000} +: 8];
        h = a[1] ? rdata[31:16] : rdata[15:0];
        unique case (funct3)
            F3_LB:   result = {{24{b[7]}}, b};
            F3_LBU:  result = {24'd0, b};
            F3_LH:   result = {{16{h[15]}}, h};
            F3_LHU:  result = {16'd0, h};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// RV32I MEM-stage load/store unit: EX/MEM access to req/ack data bus.
// Stalls the pipeline for the bus transaction, extends load data.
module mem_stage_lsu
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MEM_valid,
    input  logic        MEM_memRead,
    input  logic        MEM_memWrite,
    input  logic [2:0]  MEM_funct3,
    input  logic [31:0] MEM_aluOut,
    input  logic [31:0] MEM_rs2,
    output logic [31:0] MEM_dmemOut,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata
);

    localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_M1);

    lsu_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3_q;
    logic [1:0]       a_q;

    logic        acc;
    logic        f3_ok;
    logic        align_ok;
    logic        legal;
    logic [1:0]  a;
    logic [1:0]  sz;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ext;

    always_comb begin
        a     = MEM_aluOut[1:0];
        sz    = MEM_funct3[1:0];
        acc   = MEM_valid & (MEM_memRead | MEM_memWrite);
        // read wins when both read and write are flagged
        f3_ok = MEM_memRead ? (MEM_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU})
                            : (sz != 2'b11);
        unique case (sz)
            2'b00: begin
                align_ok = 1'b1;
                be       = 4'b0001 << a;
                wdata    = {4{MEM_rs2[7:0]}};
            end
            2'b01: begin
                align_ok = ~a[0];
                be       = 4'b0011 << a;
                wdata    = {2{MEM_rs2[15:0]}};
            end
            default: begin
                align_ok = (a == 2'b00);
                be       = 4'b1111;
                wdata    = MEM_rs2;
            end
        endcase
        legal = f3_ok & align_ok;
    end

    assign mem_stall = (state == LSU_REQ) |
                       ((state == LSU_IDLE) & acc & legal);

    lsu_load_extend u_ext (
        .rdata  (dbus_rdata),
        .a      (a_q),
        .funct3 (f3_q),
        .result (ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LSU_IDLE;
            cnt         <= '0;
            f3_q        <= '0;
            a_q         <= '0;
            dbus_req    <= 1'b0;
            dbus_we     <= 1'b0;
            dbus_addr   <= '0;
            dbus_be     <= '0;
            dbus_wdata  <= '0;
            mem_fault   <= 1'b0;
            MEM_dmemOut <= '0;
        end else begin
            mem_fault <= 1'b0;
            unique case (state)
                LSU_IDLE: begin
                    if (acc && legal) begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= ~MEM_memRead;
                        dbus_addr  <= {MEM_aluOut[31:2], 2'b00};
                        dbus_be    <= be;
                        dbus_wdata <= wdata;
                        f3_q       <= MEM_funct3;
                        a_q        <= a;
                        cnt        <= '0;
                        state      <= LSU_REQ;
                    end else if (acc) begin
                        mem_fault   <= 1'b1;
                        MEM_dmemOut <= '0;
                    end
                end
                LSU_REQ: begin
                    if (dbus_ack) begin
                        if (!dbus_we) MEM_dmemOut <= ext;
                        dbus_req <= 1'b0;
                        state    <= LSU_RESP;
                    end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
                        dbus_req    <= 1'b0;
                        mem_fault   <= 1'b1;
                        MEM_dmemOut <= '0;
                        state       <= LSU_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LSU_RESP: state <= LSU_IDLE;
                default:  state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases plus
// randomized accesses against a transaction-level reference model.
module tb_mem_stage_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MEM_valid;
    logic        MEM_memRead;
    logic        MEM_memWrite;
    logic [2:0]  MEM_funct3;
    logic [31:0] MEM_aluOut;
    logic [31:0] MEM_rs2;
    logic [31:0] MEM_dmemOut;
    logic        mem_stall;
    logic        mem_fault;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_dout;

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MEM_valid    (MEM_valid),
        .MEM_memRead  (MEM_memRead),
        .MEM_memWrite (MEM_memWrite),
        .MEM_funct3   (MEM_funct3),
        .MEM_aluOut   (MEM_aluOut),
        .MEM_rs2      (MEM_rs2),
        .MEM_dmemOut  (MEM_dmemOut),
        .mem_stall    (mem_stall),
        .mem_fault    (mem_fault),
        .dbus_req     (dbus_req),
        .dbus_we      (dbus_we),
        .dbus_addr    (dbus_addr),
        .dbus_be      (dbus_be),
        .dbus_wdata   (dbus_wdata),
        .dbus_ack     (dbus_ack),
        .dbus_rdata   (dbus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // dly: REQ cycle index at which ack is driven; >= TO means no ack
    task automatic access(input bit v, input bit r, input bit w,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [31:0] rdata,
                          input int dly);
        bit acc, ok, tmo;
        int sz, nb, off, k, ereq;
        logic [3:0]  ebe;
        logic [31:0] ewd, lane, eout;
        acc = v && (r || w);
        sz  = int'(f3[1:0]);
        off = int'(addr % 4);
        ok  = r ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (sz != 3);
        nb  = 1 << sz;
        ok  = ok && (sz != 3) && ((addr % nb) == 0);
        ebe = (sz >= 2) ? 4'hF : 4'(((1 << nb) - 1) << off);
        ewd = (sz == 0) ? rs2[7:0] * 32'h01010101 :
              (sz == 1) ? rs2[15:0] * 32'h00010001 : rs2;
        lane = rdata >> (8 * off);
        if (sz == 0)
            eout = f3[2] ? (lane & 32'hFF) : 32'($signed(lane[7:0]));
        else if (sz == 1)
            eout = f3[2] ? (lane & 32'hFFFF) : 32'($signed(lane[15:0]));
        else
            eout = rdata;
        MEM_valid = v; MEM_memRead = r; MEM_memWrite = w;
        MEM_funct3 = f3; MEM_aluOut = addr; MEM_rs2 = rs2;
        #1;
        if (!acc) begin
            chk("nomem_stall", mem_stall, 0);
            @(negedge clk);
            chk("nomem_fault", mem_fault, 0);
            chk("nomem_req", dbus_req, 0);
            chk("nomem_dout", MEM_dmemOut, exp_dout);
            MEM_valid = 1'b0;
        end else if (!ok) begin
            chk("ill_stall", mem_stall, 0);
            @(negedge clk);
            exp_dout = 0;
            chk("ill_fault", mem_fault, 1);
            chk("ill_req", dbus_req, 0);
            chk("ill_dout", MEM_dmemOut, exp_dout);
            MEM_valid = 1'b0;
            @(negedge clk);
            chk("ill_fault_end", mem_fault, 0);
            chk("ill_stall_end", mem_stall, 0);
        end else begin
            chk("idle_stall", mem_stall, 1);
            @(negedge clk);
            k = 0;
            while (dbus_req && k < 20) begin
                chk("req_stall", mem_stall, 1);
                chk("req_we", dbus_we, !r);
                chk("req_addr", dbus_addr, {addr[31:2], 2'b00});
                chk("req_be", dbus_be, ebe);
                chk("req_wdata", dbus_wdata, ewd);
                if (k == dly) begin
                    dbus_ack = 1'b1;
                    dbus_rdata = rdata;
                end
                @(negedge clk);
                dbus_ack = 1'b0;
                dbus_rdata = $urandom;
                k++;
            end
            tmo  = (dly >= TO);
            ereq = tmo ? TO : dly + 1;
            if (tmo) exp_dout = 0;
            else if (r) exp_dout = eout;
            chk("req_cycles", k, ereq);
            chk("resp_req", dbus_req, 0);
            chk("resp_stall", mem_stall, 0);
            chk("resp_fault", mem_fault, tmo);
            chk("resp_dout", MEM_dmemOut, exp_dout);
            MEM_valid = 1'b0;
            @(negedge clk);
            chk("post_stall", mem_stall, 0);
            chk("post_fault", mem_fault, 0);
            chk("post_req", dbus_req, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        MEM_valid = 0; MEM_memRead = 0; MEM_memWrite = 0;
        MEM_funct3 = 0; MEM_aluOut = 0; MEM_rs2 = 0;
        dbus_ack = 0; dbus_rdata = 0;
        exp_dout = 0;
        repeat (2) @(negedge clk);
        chk("rst_req", dbus_req, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_fault", mem_fault, 0);
        chk("rst_dout", MEM_dmemOut, 0);
        chk("rst_be", dbus_be, 0);
        chk("rst_addr", dbus_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        access(1, 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        access(1, 0, 1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1);
        access(1, 1, 0, 3'b000, 32'h102, 32'h0, 32'h0080FF00, 0);
        chk("lb_val", MEM_dmemOut, 32'hFFFFFF80);
        access(1, 1, 0, 3'b100, 32'h102, 32'h0, 32'h0080FF00, 2);
        chk("lbu_val", MEM_dmemOut, 32'h00000080);
        access(1, 1, 0, 3'b101, 32'h102, 32'h0, 32'h0080FF00, 3);
        chk("lhu_val", MEM_dmemOut, 32'h00000080);
        access(1, 1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
        chk("lw_mis_dout", MEM_dmemOut, 32'h0);
        access(1, 1, 0, 3'b010, 32'h200, 32'h0, 32'h12345678, 1);
        access(1, 0, 1, 3'b010, 32'h204, 32'h11, 32'h0, 99);
        access(1, 1, 1, 3'b001, 32'h206, 32'h0, 32'h8001_0000, 0);
        access(1, 0, 1, 3'b011, 32'h208, 32'h1, 32'h0, 0);
        access(1, 1, 0, 3'b110, 32'h208, 32'h1, 32'h0, 0);

        // ack while idle must not disturb anything
        dbus_ack = 1'b1; dbus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        dbus_ack = 1'b0;
        chk("idle_ack_dout", MEM_dmemOut, exp_dout);
        chk("idle_ack_req", dbus_req, 0);

        // reset in the middle of a request
        MEM_valid = 1; MEM_memRead = 1; MEM_memWrite = 0;
        MEM_funct3 = 3'b010; MEM_aluOut = 32'h300;
        @(negedge clk);
        chk("mid_req_hi", dbus_req, 1);
        MEM_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", dbus_req, 0);
        chk("mid_rst_stall", mem_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dbus_ack = 1'b1; dbus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        dbus_ack = 1'b0;
        exp_dout = 0;
        chk("late_ack_dout", MEM_dmemOut, 0);
        chk("late_ack_fault", mem_fault, 0);
        chk("late_ack_req", dbus_req, 0);
        chk("late_ack_we", dbus_we, 0);
        chk("late_ack_wdata", dbus_wdata, 0);
        chk("late_ack_stall", mem_stall, 0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] ad;
            ad = {20'h0, 12'($urandom)};
            access($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom),
                   3'($urandom), ad, $urandom, $urandom,
                   $urandom_range(0, TO + 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
